// File: rtl/nbit_counter_pkg.sv
// Shared constants and types for the modulo-N up/down counter family.
// Holds the saturate-mode encoding and the per-edge operation classification.
package nbit_counter_pkg;

    localparam bit MODE_WRAP = 1'b0;
    localparam bit MODE_SAT  = 1'b1;

    // What the counter does on the coming edge, in priority order load > t > hold.
    typedef enum logic [1:0] {
        OP_HOLD,
        OP_LOAD,
        OP_STEP,
        OP_END
    } op_e;

endpackage : nbit_counter_pkg

// File: rtl/dff_arn.sv
// WIDTH-bit D flip-flop with asynchronous active-low reset to zero.
// Every state bit of the counter is held in one of these.
module dff_arn #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule : dff_arn

// File: rtl/nbit_updown_counter.sv
// Modulo-MODULUS up/down counter with load, wrap/saturate end handling,
// a one-cycle wrap pulse and a sticky overflow flag cleared by load.
module nbit_updown_counter
    import nbit_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 2**WIDTH,
    parameter bit SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             t,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

    op_e              op;
    logic [WIDTH-1:0] q_next;
    logic             wrap_next;
    logic             ovf_next;

    // Terminal count looks at the live direction, so it reacts to up with no delay.
    assign tc = up ? (q == Q_MAX) : (q == '0);

    always_comb begin
        op = OP_HOLD;
        if (load) begin
            op = OP_LOAD;
        end else if (t) begin
            op = tc ? OP_END : OP_STEP;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        q_next    = q;
        wrap_next = 1'b0;
        ovf_next  = ovf;
        unique case (op)
            OP_HOLD: ;
            OP_LOAD: begin
                q_next   = (d > Q_MAX) ? Q_MAX : d;
                ovf_next = 1'b0;
            end
            OP_STEP: begin
                q_next = up ? q + WIDTH'(1) : q - WIDTH'(1);
            end
            OP_END: begin
                wrap_next = 1'b1;
                ovf_next  = 1'b1;
                // In saturate mode the count simply stays at the range end.
                if (SATURATE != MODE_SAT) begin
                    q_next = up ? '0 : Q_MAX;
                end
            end
        endcase
    end

    dff_arn #(.WIDTH(WIDTH)) u_q_reg (
        .clk   (clk),
        .rst_n (reset),
        .d     (q_next),
        .q     (q)
    );

    dff_arn #(.WIDTH(1)) u_wrap_reg (
        .clk   (clk),
        .rst_n (reset),
        .d     (wrap_next),
        .q     (wrap)
    );

    dff_arn #(.WIDTH(1)) u_ovf_reg (
        .clk   (clk),
        .rst_n (reset),
        .d     (ovf_next),
        .q     (ovf)
    );

endmodule : nbit_updown_counter

// File: tb/tb_nbit_updown_counter.sv
// Bench for nbit_updown_counter: three configurations share one stimulus stream
// and are compared against an arithmetic reference model, plus directed vectors.
module tb_nbit_updown_counter;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       t     = 1'b0;
    logic       up    = 1'b0;
    logic       load  = 1'b0;
    logic [3:0] d     = '0;

    logic [1:0] q_a;
    logic [3:0] q_b;
    logic [3:0] q_c;
    logic [3:0] qv     [3];
    logic       tc_v   [3];
    logic       wrap_v [3];
    logic       ovf_v  [3];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state per instance: a=(4,wrap) b=(10,wrap) c=(10,sat)
    int MODS [3] = '{4, 10, 10};
    bit SATS [3] = '{1'b0, 1'b0, 1'b1};
    int DMSK [3] = '{3, 15, 15};
    int mq   [3];
    bit mw   [3];
    bit mo   [3];

    always #5 clk = ~clk;

    nbit_updown_counter #(.WIDTH(2), .MODULUS(4), .SATURATE(1'b0)) u_a (
        .clk(clk), .reset(reset), .t(t), .up(up), .load(load), .d(d[1:0]),
        .q(q_a), .tc(tc_v[0]), .wrap(wrap_v[0]), .ovf(ovf_v[0])
    );
    nbit_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_b (
        .clk(clk), .reset(reset), .t(t), .up(up), .load(load), .d(d),
        .q(q_b), .tc(tc_v[1]), .wrap(wrap_v[1]), .ovf(ovf_v[1])
    );
    nbit_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_c (
        .clk(clk), .reset(reset), .t(t), .up(up), .load(load), .d(d),
        .q(q_c), .tc(tc_v[2]), .wrap(wrap_v[2]), .ovf(ovf_v[2])
    );

    assign qv[0] = {2'b00, q_a};
    assign qv[1] = q_b;
    assign qv[2] = q_c;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i] = 0;
            mw[i] = 1'b0;
            mo[i] = 1'b0;
        end
    endtask

    // Counting modelled as signed integer arithmetic with an explicit range check.
    task automatic model_edge();
        int dv;
        int raw;
        if (!reset) return;
        for (int i = 0; i < 3; i++) begin
            dv = int'(d) & DMSK[i];
            if (load) begin
                mq[i] = (dv < MODS[i]) ? dv : MODS[i] - 1;
                mw[i] = 1'b0;
                mo[i] = 1'b0;
            end else if (t) begin
                raw = mq[i] + (up ? 1 : -1);
                if (raw < 0 || raw >= MODS[i]) begin
                    mw[i] = 1'b1;
                    mo[i] = 1'b1;
                    if (!SATS[i]) mq[i] = (raw + MODS[i]) % MODS[i];
                end else begin
                    mq[i] = raw;
                    mw[i] = 1'b0;
                end
            end else begin
                mw[i] = 1'b0;
            end
        end
    endtask

    function automatic bit model_tc(input int i);
        return up ? (mq[i] == MODS[i] - 1) : (mq[i] == 0);
    endfunction

    task automatic compare_model(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s u%0d q", tag, i), 32'(qv[i]), mq[i]);
            check($sformatf("%s u%0d wrap", tag, i), 32'(wrap_v[i]), 32'(mw[i]));
            check($sformatf("%s u%0d ovf", tag, i), 32'(ovf_v[i]), 32'(mo[i]));
            check($sformatf("%s u%0d tc", tag, i), 32'(tc_v[i]), 32'(model_tc(i)));
        end
    endtask

    task automatic drive(input bit l, input bit tt, input bit u, input logic [3:0] dd);
        load = l;
        t    = tt;
        up   = u;
        d    = dd;
    endtask

    // One clock: model follows the rising edge, outputs are sampled on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Assert reset between edges and check the clear happens without any clock.
    task automatic mid_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare_model(tag);
    endtask

    typedef struct {
        bit         load;
        bit         t;
        bit         up;
        logic [3:0] d;
        int         q;
        bit         wrap;
        bit         ovf;
        bit         tc;
    } vec_t;

    vec_t vecs [13];

    int exp_q033    [5] = '{1, 2, 3, 0, 1};
    bit exp_wrap033 [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bit exp_ovf033  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bit exp_wrap035 [3] = '{1'b0, 1'b1, 1'b1};

    initial begin
        // Directed vectors for the MODULUS=10 wrapping instance.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'd0,  0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 4'd0,  9, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 4'd12, 9, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 4'd5,  5, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 4'd2,  2, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 4'd0,  3, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'd0,  2, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 4'd0,  3, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 4'd0,  2, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 4'd9,  9, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 4'd0,  9, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 4'd0,  0, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 4'd0,  0, 1'b0, 1'b1, 1'b1};

        // Reset: inputs active while reset is low must have no effect.
        #1;
        reset = 1'b0;
        model_reset();
        drive(1'b1, 1'b1, 1'b1, 4'd7);
        repeat (2) cycle();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset u%0d q", i), 32'(qv[i]), 0);
            check($sformatf("reset u%0d wrap", i), 32'(wrap_v[i]), 0);
            check($sformatf("reset u%0d ovf", i), 32'(ovf_v[i]), 0);
        end
        drive(1'b0, 1'b1, 1'b1, 4'd0);
        reset = 1'b1;

        // Free-running up count through the top of a 2-bit range.
        for (int k = 0; k < 5; k++) begin
            cycle();
            check($sformatf("wrap4 e%0d q", k), 32'(q_a), exp_q033[k]);
            check($sformatf("wrap4 e%0d wrap", k), 32'(wrap_v[0]), 32'(exp_wrap033[k]));
            check($sformatf("wrap4 e%0d ovf", k), 32'(ovf_v[0]), 32'(exp_ovf033[k]));
            compare_model($sformatf("wrap4 e%0d", k));
        end

        for (int k = 0; k < 13; k++) begin
            drive(vecs[k].load, vecs[k].t, vecs[k].up, vecs[k].d);
            cycle();
            check($sformatf("vec%0d q", k), 32'(q_b), vecs[k].q);
            check($sformatf("vec%0d wrap", k), 32'(wrap_v[1]), 32'(vecs[k].wrap));
            check($sformatf("vec%0d ovf", k), 32'(ovf_v[1]), 32'(vecs[k].ovf));
            check($sformatf("vec%0d tc", k), 32'(tc_v[1]), 32'(vecs[k].tc));
            compare_model($sformatf("vec%0d", k));
        end

        // Saturating instance pinned at the top of its range.
        drive(1'b1, 1'b0, 1'b1, 4'd8);
        cycle();
        drive(1'b0, 1'b1, 1'b1, 4'd0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check($sformatf("sat e%0d q", k), 32'(q_c), 9);
            check($sformatf("sat e%0d tc", k), 32'(tc_v[2]), 1);
            check($sformatf("sat e%0d wrap", k), 32'(wrap_v[2]), 32'(exp_wrap035[k]));
            compare_model($sformatf("sat e%0d", k));
        end

        // Count to 3 with ovf set, then reset between edges.
        drive(1'b1, 1'b0, 1'b1, 4'd9);
        cycle();
        drive(1'b0, 1'b1, 1'b1, 4'd0);
        repeat (4) cycle();
        check("pre-rst q", 32'(q_b), 3);
        check("pre-rst ovf", 32'(ovf_v[1]), 1);
        mid_reset("async rst");
        check("async rst q", 32'(q_b), 0);
        check("async rst ovf", 32'(ovf_v[1]), 0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check($sformatf("in rst e%0d q", k), 32'(q_b), 0);
        end
        reset = 1'b1;
        cycle();
        check("post rst q", 32'(q_b), 1);
        compare_model("post rst");

        // Randomized traffic with occasional asynchronous resets.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(49) == 0) begin
                mid_reset($sformatf("rnd%0d rst", k));
                drive($urandom_range(1) == 0, 1'($urandom_range(1)), 1'($urandom_range(1)), 4'($urandom_range(15)));
                cycle();
                compare_model($sformatf("rnd%0d inrst", k));
                reset = 1'b1;
            end else begin
                drive($urandom_range(7) == 0, 1'($urandom_range(1)), 1'($urandom_range(1)), 4'($urandom_range(15)));
                cycle();
                compare_model($sformatf("rnd%0d", k));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_nbit_updown_counter

// File: doc/nbit_updown_counter.md
NBIT_UPDOWN_COUNTER -- requirements
Module: nbit_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits (>= 1).
REQ-002 Parameter MODULUS, default 2**WIDTH, count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH).
REQ-003 Parameter SATURATE, default 0: 0 = wrap at range ends, 1 = hold at range ends.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 t  input  1  trigger; count advances one step on each clock edge where t=1.
REQ-007 up  input  1  direction: 1 = increment, 0 = decrement; sampled with t.
REQ-008 load  input  1  synchronous load strobe.
REQ-009 d  input  WIDTH  load value.
REQ-010 q  output  WIDTH  current count, registered.
REQ-011 tc  output  1  terminal count, combinational: (up=1 and q=MODULUS-1) or (up=0 and q=0).
REQ-012 wrap  output  1  registered one-cycle pulse, asserted the cycle after a wrap or saturation-block event.
REQ-013 ovf  output  1  registered sticky flag, set by any wrap or saturation-block event.

Function
REQ-014 Priority per edge SHALL be load > t > hold.
REQ-015 load=1: q <= d if d <= MODULUS-1, else q <= MODULUS-1; wrap <= 0; ovf <= 0 (load clears ovf).
REQ-016 load=0, t=1, up=1, q < MODULUS-1: q <= q+1.
REQ-017 load=0, t=1, up=0, q > 0: q <= q-1.
REQ-018 load=0, t=1, tc=1, SATURATE=0: q wraps (MODULUS-1 -> 0 up, 0 -> MODULUS-1 down); wrap <= 1; ovf <= 1.
REQ-019 load=0, t=1, tc=1, SATURATE=1: q holds; wrap <= 1; ovf <= 1.
REQ-020 load=0, t=0: q and ovf hold; wrap <= 0.
REQ-021 wrap SHALL be 0 on every edge not covered by REQ-018/019.
REQ-022 Arithmetic SHALL be WIDTH bits, modulo MODULUS; q SHALL never exceed MODULUS-1.
REQ-023 Latency t -> q SHALL be one clock edge; tc SHALL follow q and up with zero latency.
REQ-024 Changing up on the same edge as t=1 SHALL use the new up value sampled on that edge.

Reset
REQ-025 reset=0 SHALL force q=0, wrap=0, ovf=0 immediately, regardless of clk.
REQ-026 While reset=0, t and load SHALL be ignored.
REQ-027 On reset deassertion, the first edge SHALL follow REQ-014..020 from q=0.
REQ-028 Reset mid-load or mid-count SHALL discard the pending operation; no partial update.

Structure
REQ-029 Shared package nbit_counter_pkg SHALL hold the SATURATE mode constants (MODE_WRAP=0, MODE_SAT=1).
REQ-030 Registers SHALL be built from one sub-module, dff_arn: a WIDTH-parametrised D flip-flop with asynchronous active-low reset to 0.
REQ-031 Next-state logic (load mux, inc/dec, wrap/saturate select, clamp) SHALL be combinational in the top module.
REQ-032 wrap and ovf SHALL each use a 1-bit dff_arn instance.

Verification
REQ-033 WIDTH=2, MODULUS=4, SATURATE=0, up=1, t=1 for 5 edges from reset -> q = 1,2,3,0,1; wrap=1 only the cycle q shows 0; ovf=1 from then on.
REQ-034 WIDTH=4, MODULUS=10, SATURATE=0, up=0, t=1 from q=0 -> q=9, wrap=1, ovf=1; load d=12 -> q=9, ovf=0.
REQ-035 WIDTH=4, MODULUS=10, SATURATE=1, load d=8, up=1, t=1 for 3 edges -> q = 9,9,9; tc=1 at q=9; wrap=1 on edges 2 and 3.
REQ-036 load=1, d=5, t=1, up=1 on the same edge -> q=5 (load wins), wrap=0.
REQ-037 Count to q=3, assert reset=0 between edges -> q=0, ovf=0 without a clock edge; t ignored until release.
REQ-038 Alternate up=1/up=0 with t=1 each edge from q=2 -> q = 3,2,3,2; tc=1 exactly when q=MODULUS-1 with up=1 or q=0 with up=0.
